// File: rtl/core_types_pkg.sv
// Shared ALU result types used by the writeback-side result buffer.
package core_types_pkg;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 5;

  typedef logic [3:0] aluop_t;

  // One buffered ALU result: producing op, result word and destination tag.
  typedef struct packed {
    aluop_t              op;
    logic [WORD_W-1:0]   data;
    logic [TAG_W-1:0]    tag;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// ALU-side push port and writeback-side pop port of the result buffer.
interface alu_result_fifo_if
  import core_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);

  logic                       flush;

  logic                       in_valid;
  logic                       in_ready;
  aluop_t                     in_op;
  logic [WORD_W-1:0]          in_out;
  logic [TAG_W-1:0]           in_tag;

  logic                       out_valid;
  logic                       out_ready;
  aluop_t                     out_op;
  logic [WORD_W-1:0]          out_data;
  logic [TAG_W-1:0]           out_tag;
  logic                       out_zero;

  logic [$clog2(DEPTH):0]     count;

  // Driven by the ALU / writeback side.
  modport master (
    output flush,
    output in_valid, in_op, in_out, in_tag,
    input  in_ready,
    input  out_valid, out_op, out_data, out_tag, out_zero,
    output out_ready,
    input  count
  );

  // Implemented by the buffer itself.
  modport slave (
    input  flush,
    input  in_valid, in_op, in_out, in_tag,
    output in_ready,
    output out_valid, out_op, out_data, out_tag, out_zero,
    input  out_ready,
    output count
  );

endinterface

// File: rtl/alu_result_fifo.sv
// In-order result buffer between the single-cycle ALU and the writeback
// stage. Handshake outputs depend only on the registered occupancy count,
// so there is no combinational path from the push side to the pop side.
// TAG_W must match core_types_pkg::TAG_W because storage uses the shared
// alu_result_t struct.
module alu_result_fifo
  import core_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic               CLK,
  input  logic               nRST,
  alu_result_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  alu_result_t        mem_q [DEPTH];
  alu_result_t        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               push;
  logic               pop;
  alu_result_t        head;

  // Handshake qualifiers from registered occupancy only.
  always_comb begin
    bus.in_ready  = (count_q != FULL_CNT);
    bus.out_valid = (count_q != '0);
    push          = bus.in_valid  & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
  end

  // Next-state for storage, pointers and count; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{op: bus.in_op, data: bus.in_out, tag: bus.in_tag};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers; reset also clears storage so the head reads as zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation. out_zero is qualified by out_valid so it reads 0
  // out of reset (storage cleared) while still flagging a valid zero result.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    bus.out_op   = head.op;
    bus.out_data = head.data;
    bus.out_tag  = head.tag;
    bus.out_zero = bus.out_valid & (head.data == '0);
    bus.count    = count_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed checks of alu_result_fifo against a queue model.
module tb_alu_result_fifo;
  import core_types_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  alu_result_fifo_if #(.DEPTH(DEPTH), .TAG_W(TAGW)) bus ();

  alu_result_fifo #(.DEPTH(DEPTH), .TAG_W(TAGW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 0;
  logic m_acc;
  exp_t m_ent;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted results with capacity DEPTH.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb.delete();
    end else if (bus.flush) begin
      sb.delete();
    end else begin
      m_acc = bus.in_valid && (sb.size() < DEPTH);
      if (bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (m_acc) begin
        m_ent.op   = bus.in_op;
        m_ent.data = bus.in_out;
        m_ent.tag  = bus.in_tag;
        sb.push_back(m_ent);
      end
    end
  end

  // Monitor: compares the presented head and occupancy with the model.
  always @(negedge CLK) begin
    if (mon_en && nRST) begin
      chk("count", 32'(bus.count), 32'(sb.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
      if (sb.size() > 0) begin
        chk("head_op", 32'(bus.out_op), 32'(sb[0].op));
        chk("head_data", bus.out_data, sb[0].data);
        chk("head_tag", 32'(bus.out_tag), 32'(sb[0].tag));
        chk("head_zero", 32'(bus.out_zero), 32'(sb[0].data == 32'h0));
      end
    end
  end

  // Apply inputs (just after a falling edge), let one rising edge consume
  // them, return on the following falling edge.
  task automatic step(logic iv, logic [3:0] op, logic [31:0] d, logic [4:0] tg,
                      logic ordy, logic fl);
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_out    = d;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(string nm);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_ready"}, 32'(bus.in_ready), 32'd1);
    chk({nm, "_count"}, 32'(bus.count), 32'd0);
    chk({nm, "_data"}, bus.out_data, 32'd0);
    chk({nm, "_op"}, 32'(bus.out_op), 32'd0);
    chk({nm, "_tag"}, 32'(bus.out_tag), 32'd0);
    chk({nm, "_zero"}, 32'(bus.out_zero), 32'd0);
  endtask

  logic        r_iv, r_ordy, r_fl, r_acc;
  logic [3:0]  r_op;
  logic [31:0] r_d;
  logic [4:0]  r_tg;

  initial begin
    nRST          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_out    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #22;
    chk_reset_outputs("rst");
    @(negedge CLK);
    nRST   = 1'b1;
    mon_en = 1'b1;

    // First push visible after one edge.
    step(1'b1, 4'h1, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", bus.out_data, 32'hDEAD_BEEF);
    chk("t1_tag", 32'(bus.out_tag), 32'd3);
    chk("t1_count", 32'(bus.count), 32'd1);
    step(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("t1_drained", 32'(bus.count), 32'd0);

    // Fill to capacity, then stall a fifth push.
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i + 2), 32'h1000 + 32'(i), 5'(i), 1'b0, 1'b0);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd4);
    step(1'b1, 4'h9, 32'h55, 5'd9, 1'b0, 1'b0);
    chk("stall_count", 32'(bus.count), 32'd4);
    chk("stall_head", bus.out_data, 32'h1000);
    // Full with push and pop: only the pop happens.
    step(1'b1, 4'h9, 32'h55, 5'd9, 1'b1, 1'b0);
    chk("fullpop_count", 32'(bus.count), 32'd3);
    chk("fullpop_ready", 32'(bus.in_ready), 32'd1);
    chk("fullpop_head", bus.out_data, 32'h1001);
    step(1'b1, 4'h9, 32'h55, 5'd9, 1'b1, 1'b0);
    chk("reopen_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Steady push+pop at count 1 across pointer wrap.
    step(1'b1, 4'hA, 32'h2000, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), 32'h3000 + 32'(i), 5'(i + 4), 1'b1, 1'b0);
      chk("steady_count", 32'(bus.count), 32'd1);
      chk("steady_data", bus.out_data, 32'h3000 + 32'(i));
    end
    step(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Flush overrides simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'h3, 32'h4000 + 32'(i), 5'd7, 1'b0, 1'b0);
    chk("preflush_count", 32'(bus.count), 32'd3);
    step(1'b1, 4'h3, 32'h4444, 5'd7, 1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);

    // Zero flag follows the head.
    step(1'b1, 4'h2, 32'h0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 32'h1, 5'd2, 1'b0, 1'b0);
    chk("zero_first", 32'(bus.out_zero), 32'd1);
    step(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("zero_after", 32'(bus.out_zero), 32'd0);
    chk("zero_after_data", bus.out_data, 32'h1);
    step(1'b1, 4'h5, 32'h77, 5'd5, 1'b0, 1'b0);
    chk("prerst_count", 32'(bus.count), 32'd2);

    // Asynchronous reset mid-cycle.
    bus.in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge CLK);
    nRST = 1'b1;

    // Randomised traffic; a stalled push is held until accepted.
    r_iv = 1'b0; r_acc = 1'b1;
    r_op = '0; r_d = '0; r_tg = '0;
    for (int c = 0; c < 600; c++) begin
      if (!(r_iv && !r_acc)) begin
        r_iv = ($urandom_range(0, 3) != 0);
        r_op = 4'($urandom);
        r_d  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        r_tg = 5'($urandom);
      end
      r_ordy = ($urandom_range(0, 2) != 0);
      r_fl   = ($urandom_range(0, 40) == 0);
      r_acc  = r_iv && bus.in_ready && !r_fl;
      step(r_iv, r_op, r_d, r_tg, r_ordy, r_fl);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("final_count", 32'(bus.count), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
